// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write-side companion to the read-only instruction memory. This block
//   receives a program as a byte stream over a valid/ready handshake and
//   assembles little-endian 32-bit words. Each word goes out as a
//   single-cycle write at consecutive word-aligned byte addresses, starting
//   at BASE_ADDR. The CPU is held in reset until the load has finished.
//
// Parameters
//   WORDS      instruction memory capacity in words; longer loads are rejected
//   BASE_ADDR  byte address of the first written word
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   start       begins a load (honoured in IDLE or DONE only)
//   len_words   number of words to load, latched on an accepted start
//   byte_valid  byte_data carries a valid byte
//   byte_data   program byte, little-endian within each word
//   byte_ready  loader accepts a byte this cycle
//   WE          instruction memory write enable, one pulse per word
//   WA          write byte address (BASE_ADDR + 4*word_index)
//   WD          assembled write data
//   busy        load in progress (RECV or WRITE)
//   done        last load finished or was rejected
//   err         last load was rejected (len_words > WORDS)
//   cpu_hold    hold the CPU in reset; low only in DONE
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] len_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        WE,
  output logic [31:0] WA,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [16:0] WORDS_L = 17'(WORDS);

  state_e      state_q;
  logic [1:0]  byte_cnt_q;
  logic [15:0] word_cnt_q;
  logic [15:0] len_q;
  logic [31:0] asm_q;
  logic [31:0] asm_d;

  logic        byte_ready_q;
  logic        we_q;
  logic [31:0] wa_q;
  logic [31:0] wd_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        cpu_hold_q;

  logic        xfer;
  logic        too_long;
  logic [31:0] addr_d;

  // byte_ready_q is only ever high in RECV, so it alone qualifies a transfer.
  assign xfer     = byte_valid & byte_ready_q;
  assign too_long = {1'b0, len_words} > WORDS_L;
  assign addr_d   = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset
  // branch is synchronous, sampled on the same rising edge as everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= 16'd0;
      len_q        <= 16'd0;
      asm_q        <= 32'd0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      wa_q         <= BASE_ADDR;
      wd_q         <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      // The write strobe is a one-cycle pulse; only the RECV->WRITE
      // transition raises it again.
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q      <= len_words;
            err_q      <= 1'b0;
            word_cnt_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            if (len_words == 16'd0) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else if (too_long) begin
              err_q      <= 1'b1;
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q      <= S_RECV;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              cpu_hold_q   <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (xfer) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;  // wraps to 0 after the 4th byte
            if (byte_cnt_q == 2'd3) begin
              // Present the finished word directly from asm_d so the write
              // pulse lands in the cycle right after the 4th byte.
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              we_q         <= 1'b1;
              wa_q         <= addr_d;
              wd_q         <= asm_d;
            end
          end
        end

        S_WRITE: begin
          if (word_cnt_q == len_q - 16'd1) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            word_cnt_q   <= word_cnt_q + 16'd1;
            state_q      <= S_RECV;
            byte_ready_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign WE         = we_q;
  assign WA         = wa_q;
  assign WD         = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Stimulus tasks push each expected write
//   (address, data) into a queue; a separate monitor pops and compares it
//   whenever WE is seen high. Status flags are checked directly after each
//   load phase.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int unsigned WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] len_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        WE;
  logic [31:0] WA;
  logic [31:0] WD;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  imem_loader #(
    .WORDS    (WORDS),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len_words (len_words),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Monitor: byte_ready must be high exactly in RECV (busy and not writing);
  // every WE pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_in_recv", {31'd0, byte_ready}, {31'd0, busy && !WE});
      if (WE) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write_addr", WA, 32'hFFFF_FFFF);
        end else begin
          wr_t exp_wr;
          exp_wr = sb_q.pop_front();
          check("write_addr", WA, exp_wr.wa);
          check("write_data", WD, exp_wr.wd);
        end
      end
    end
  end

  task automatic expect_write(input logic [31:0] wa, input logic [31:0] wd);
    wr_t w;
    w.wa = wa;
    w.wd = wd;
    sb_q.push_back(w);
  endtask

  // Called and returns on a falling edge. Offers one byte until accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'hXX;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      send_byte(b, gap);
    end
  endtask

  task automatic pulse_start(input logic [15:0] len);
    start     = 1'b1;
    len_words = len;
    @(negedge clk);
    start     = 1'b0;
    len_words = 16'd0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
    check("cpu_released", {31'd0, cpu_hold}, 32'd0);
    check("not_busy", {31'd0, busy}, 32'd0);
    check("all_writes_seen", sb_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, WE}, 32'd0);
    check("rst_wa", WA, 32'h0);
    check("rst_wd", WD, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
  endtask

  logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h50, 8'h00,
                           8'h93, 8'h00, 8'hA0, 8'h00};

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len_words  = 16'd0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 1) Two-word load, byte_valid held high.
    expect_write(32'h0, 32'h0050_0013);
    expect_write(32'h4, 32'h00A0_0093);
    pulse_start(16'd2);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("hold_during_load", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b0);
    wait_done();
    check("err_clean_load", {31'd0, err}, 32'd0);

    // 2) Same load, byte_valid toggling every cycle.
    expect_write(32'h0, 32'h0050_0013);
    expect_write(32'h4, 32'h00A0_0093);
    pulse_start(16'd2);
    check("done_drops_on_restart", {31'd0, done}, 32'd0);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b1);
    wait_done();

    // 3) Oversize load is rejected, then a 1-word load clears err.
    pulse_start(16'(WORDS + 1));
    check("oversize_done", {31'd0, done}, 32'd1);
    check("oversize_err", {31'd0, err}, 32'd1);
    check("oversize_not_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    expect_write(32'h0, 32'hDEAD_BEEF);
    pulse_start(16'd1);
    check("err_cleared", {31'd0, err}, 32'd0);
    check("hold_back_on", {31'd0, cpu_hold}, 32'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done();

    // 4) Zero-length load, then a 3-word load with a stray start mid-way.
    pulse_start(16'd0);
    check("zero_len_done", {31'd0, done}, 32'd1);
    check("zero_len_err", {31'd0, err}, 32'd0);
    expect_write(32'h0, 32'h1111_1111);
    expect_write(32'h4, 32'h2222_2222);
    expect_write(32'h8, 32'h3333_3333);
    pulse_start(16'd3);
    send_word(32'h1111_1111, 1'b0);
    @(negedge clk);
    pulse_start(16'd1);
    check("busy_ignores_start", {31'd0, busy}, 32'd1);
    send_word(32'h2222_2222, 1'b0);
    send_word(32'h3333_3333, 1'b1);
    wait_done();

    // 5) Reset after 2 words and 2 bytes of a 4-word load.
    expect_write(32'h0, 32'hA5A5_0001);
    expect_write(32'h4, 32'hA5A5_0002);
    pulse_start(16'd4);
    send_word(32'hA5A5_0001, 1'b0);
    send_word(32'hA5A5_0002, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("no_we_after_reset", {31'd0, WE}, 32'd0);
    for (int i = 0; i < 4; i++) expect_write(32'(4 * i), 32'h5000_0000 + 32'(i));
    pulse_start(16'd4);
    for (int i = 0; i < 4; i++) send_word(32'h5000_0000 + 32'(i), 1'b0);
    wait_done();

    // 6) Full-capacity load; last write lands at 0xFC with 0xC0DE003F.
    for (int i = 0; i < int'(WORDS); i++)
      expect_write(32'(4 * i), 32'hC0DE_0000 + 32'(i));
    pulse_start(16'(WORDS));
    for (int i = 0; i < int'(WORDS); i++)
      send_word(32'hC0DE_0000 + 32'(i), 1'b0);
    wait_done();
    check("last_wa_held", WA, 32'h0000_00FC);
    check("last_wd_held", WD, 32'hC0DE_003F);
    check("full_load_err", {31'd0, err}, 32'd0);

    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the read-only instruction_memory (address A in, word RD out). It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into instruction memory through a single-cycle write port at consecutive word-aligned byte addresses. The CPU is held in reset until the load completes.

Parameters:
WORDS, 64, instruction memory capacity in 32-bit words; load lengths above this are rejected.
BASE_ADDR, 32'h00000000, byte address of the first written word.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
start  input  1  pulse that begins a load; honoured only in IDLE or DONE.
len_words  input  16  number of words to load; latched when start is accepted.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  program byte, little-endian within each word.
byte_ready  output  1  loader accepts a byte this cycle.
WE  output  1  instruction memory write enable, one-cycle pulse per word.
WA  output  32  write byte address = BASE_ADDR + 4*word_index.
WD  output  32  assembled write data.
busy  output  1  load in progress (RECV or WRITE).
done  output  1  last load finished, or was rejected.
err  output  1  last load was rejected because len_words > WORDS.
cpu_hold  output  1  hold the CPU in reset; 0 only in DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, byte_cnt=0, word_cnt=0, assembly register=0. Outputs: byte_ready=0, WE=0, WA=BASE_ADDR, WD=0, busy=0, done=0, err=0, cpu_hold=1. A reset mid-load aborts the load immediately. Words already written stay in memory.
- Byte transfer occurs only when byte_valid and byte_ready are both 1 at a rising edge. byte_data may change freely while byte_ready=0.
- States:
  - IDLE: byte_ready=0. On start, latch len_words and clear err.
    - len_words=0: go to DONE.
    - len_words>WORDS: set err=1 and go to DONE. No write occurs.
    - Otherwise: word_cnt=0, byte_cnt=0, go to RECV.
  - RECV: byte_ready=1, busy=1. On each transfer, byte k (k=byte_cnt) is placed in bits [8k+7:8k] and byte_cnt increments. On the 4th byte (byte_cnt=3), byte_cnt wraps to 0 and the state goes to WRITE. With no transfer, hold all state indefinitely.
  - WRITE: exactly one cycle. WE=1, WA=BASE_ADDR+4*word_cnt, WD=assembled word, byte_ready=0, busy=1. Next:
    - word_cnt = len-1: go to DONE.
    - Otherwise: word_cnt increments and the state returns to RECV.
  - DONE: done=1, busy=0, cpu_hold=0, byte_ready=0. err keeps its value. A new start behaves as from IDLE: done drops the next cycle and cpu_hold returns to 1.
- Latency: the WE pulse occurs in the cycle after the edge that accepts the 4th byte. The minimum rate is 5 cycles per word.
- start is ignored while busy=1.
- Bytes offered outside RECV are never consumed, because byte_ready=0.
- WA is held stable between writes. WE is 0 in every state except WRITE.
- Width rules: word_cnt is 16 bits. The address computation is 32-bit, with word_cnt zero-extended and shifted left by 2.

Test Plan:
- Reset, then start with len_words=2. Bytes 13,00,50,00,93,00,A0,00 sent with byte_valid held high → WE pulses twice: WA=0x0 with WD=0x00500013, then WA=0x4 with WD=0x00A00093. Then done=1 and cpu_hold=0; in the tb_instruction_memory flow, A=0x0 reads back 0x00500013.
- Same load with byte_valid toggling 1,0,1,0 each cycle → identical WA/WD sequence. No byte is lost or duplicated. byte_ready stays 1 throughout RECV.
- Start with len_words=WORDS+1 (65) → no WE pulse, err=1, done=1 one cycle later. A following start with len_words=1 clears err.
- Start with len_words=0 → done=1 on the next cycle with no WE pulse. Start pulsed again mid-load with len_words=3 → the second start is ignored and the load completes 3 words.
- rst_n=0 after 2 words and 2 bytes of a 4-word load → state IDLE, all outputs at reset values, and no WE pulse on the following cycle. A subsequent full 4-word load writes WA=0x0, 0x4, 0x8, 0xC.
- Full load of 64 words with word i = 32'hC0DE0000+i → the last write is WA=0xFC, WD=0xC0DE003F, then done=1.
